// File: rtl/processor_pkg.sv
// Shared definitions for the 16-bit teaching processor. This package holds
// the controller state codes, the ISA opcodes and the ALU operation codes.
package processor_pkg;

    // Controller states. StateO shows these codes on the hex displays, so
    // the values are fixed.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    // Opcodes live in IR[15:12]. Opcodes 6-15 are unused and execute as NOOP.
    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    // ALU operation select.
    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2
    } alu_op_t;

    // Maps an opcode to the first execute state entered after Decode.
    function automatic state_t exec_state(input logic [3:0] opcode);
        case (opcode)
            OP_STORE: return ST_STORE;
            OP_LOAD:  return ST_LOAD_A;
            OP_ADD:   return ST_ADD;
            OP_SUB:   return ST_SUB;
            OP_HALT:  return ST_HALT;
            default:  return ST_NOOP;
        endcase
    endfunction

endpackage

// File: rtl/program_counter.sv
// 8-bit program counter. It clears in Init and increments in Fetch, and it
// wraps from 0xFF to 0x00 without a flag.
module program_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] pc
);

    // PC register: clear takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
        if (!rst_n) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (inc) begin
            pc <= pc + 8'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller. It owns the PC and the IR and drives every
// datapath control line. All outputs are a Moore decode of the state register
// and the IR, so reset clears them immediately without waiting for a clock.
module control_unit
    import processor_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] I_data,
    output logic        I_rd,
    output logic [7:0]  PC_Out,
    output logic [15:0] IR_Out,
    output logic [3:0]  StateO,
    output logic [7:0]  D_addr,
    output logic        D_rd,
    output logic        D_wr,
    output logic        RF_s,
    output logic [3:0]  RF_W_addr,
    output logic        RF_W_en,
    output logic [3:0]  RF_Ra_addr,
    output logic [3:0]  RF_Rb_addr,
    output logic [2:0]  ALU_s0
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;
    logic        pc_clr;
    logic        pc_inc;

    assign pc_clr = (state_q == ST_INIT);
    assign pc_inc = (state_q == ST_FETCH);

    program_counter u_pc (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (PC_Out)
    );

    // State register; asynchronous reset returns to Init.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction register, loaded from the ROM in Fetch and held otherwise.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ir_q <= '0;
        end else if (state_q == ST_FETCH) begin
            ir_q <= I_data;
        end
    end

    assign IR_Out = ir_q;
    assign StateO = state_q;

    // Next-state selection and Moore decode of the datapath control lines.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        ALU_s0     = ALU_PASS;

        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                I_rd    = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = exec_state(ir_q[15:12]);
            end
            ST_NOOP: begin
                state_d = ST_FETCH;
            end
            ST_LOAD_A: begin
                D_addr    = ir_q[7:0];
                D_rd      = 1'b1;
                RF_W_addr = ir_q[11:8];
                state_d   = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                // The data memory returns the word requested in Load_A in this cycle.
                D_addr    = ir_q[7:0];
                D_rd      = 1'b1;
                RF_W_addr = ir_q[11:8];
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_STORE: begin
                D_addr     = ir_q[7:0];
                D_wr       = 1'b1;
                RF_Ra_addr = ir_q[11:8];
                state_d    = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_W_addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                ALU_s0     = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
